// File: rtl/mul_sequencer_if.sv
// Bundle between the MUL/MLA sequencer, the issuing execute stage and the shared ALU.
// The master side issues requests and returns the ALU result; the slave side is the sequencer.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  // request
  logic             start;
  logic             accumulate;
  logic             set_flags;
  logic [WIDTH-1:0] rm_val;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rn_val;
  // response
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             n_flag;
  logic             z_flag;
  logic             flags_we;
  // ALU borrow
  logic             alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [31:0]      alu_opcode;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output start, accumulate, set_flags, rm_val, rs_val, rn_val, alu_result,
    input  busy, done, result, n_flag, z_flag, flags_we,
    input  alu_sel, alu_a, alu_b, alu_opcode, alu_cin
  );

  modport slave (
    input  start, accumulate, set_flags, rm_val, rs_val, rn_val, alu_result,
    output busy, done, result, n_flag, z_flag, flags_we,
    output alu_sel, alu_a, alu_b, alu_opcode, alu_cin
  );
endinterface

// File: rtl/mul_sequencer.sv
// ARM MUL/MLA sequencer: radix-2 shift-add on the shared execute ALU, one add per cycle,
// optionally stopping as soon as the remaining multiplier bits are all zero.
module mul_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  mul_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          CNT_W      = $clog2(WIDTH);
  localparam logic [31:0] ADD_OPCODE = 32'hE080_0000;  // ADD, register form, ALU op 0100

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] iter_cnt;
  logic             s_q;
  logic             last_iter;

  // The final add is the one after which no set multiplier bits remain, or the WIDTH-th add.
  assign last_iter = (EARLY_TERM && ((mplier >> 1) == '0)) ||
                     (iter_cnt == CNT_W'(WIDTH - 1));

  // NOTE: every state/data register is updated with <= so that all flops sample the
  // values from before the edge; mixing in = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the operand registers are reset too, so an aborted multiply leaves nothing
  // stale visible on result and the flags after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result_q <= '0;
      iter_cnt <= '0;
      s_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc      <= bus.accumulate ? bus.rn_val : '0;
            mcand    <= bus.rm_val;
            mplier   <= bus.rs_val;
            s_q      <= bus.set_flags;
            iter_cnt <= '0;
          end
        end
        ITER: begin
          acc      <= bus.alu_result;
          mcand    <= mcand << 1;
          mplier   <= mplier >> 1;
          iter_cnt <= iter_cnt + 1'b1;
          // Capture the product as DONE is entered so it is valid alongside done.
          if (last_iter) result_q <= bus.alu_result;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every signal written below gets a default first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.flags_we   = 1'b0;
    bus.alu_sel    = 1'b0;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_opcode = '0;
    bus.alu_cin    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) state_nxt = ITER;
      end
      ITER: begin
        bus.busy       = 1'b1;
        bus.alu_sel    = 1'b1;
        bus.alu_a      = acc;
        bus.alu_b      = mplier[0] ? mcand : '0;
        bus.alu_opcode = ADD_OPCODE;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        bus.busy     = 1'b1;
        bus.done     = 1'b1;
        bus.flags_we = s_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.result = result_q;
  assign bus.n_flag = result_q[WIDTH-1];
  assign bus.z_flag = (result_q == '0);

endmodule
